pe_result_drain: RTL and testbench
==================================

Name: pe_result_drain

Overview:
- Output stage directly downstream of the processing-element datapath inside tt_um_pe_simonbju.
- Captures result words from the PE into a small FIFO and serializes each word onto the 8-bit dedicated output bus, low byte first.
- Each byte is held on the bus until the external host acknowledges it.
- The PE never stalls, so words arriving while the FIFO is full are dropped and flagged.

Parameters:
- DATA_W, 16: result word width in bits; must be a multiple of 8, range 8..32.
- DEPTH, 4: FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: design-select enable; when low, the block is frozen.
- res_data, input, DATA_W: result word from the PE.
- res_valid, input, 1: res_data valid this cycle (single-cycle pulse per word).
- res_ready, output, 1: FIFO not full; advisory only, the PE ignores it.
- out_byte, output, 8: current byte presented to the host.
- out_valid, output, 1: out_byte is valid and awaiting acknowledge.
- out_last, output, 1: out_byte is the most significant byte of its word.
- out_ack, input, 1: host acknowledge; already synchronized, one-cycle pulse.
- fifo_count, output, $clog2(DEPTH)+1: current FIFO occupancy.
- ovf, output, 1: sticky overflow flag.
- clr_ovf, input, 1: clears ovf.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert at the source): out_byte=0, out_valid=0, out_last=0, fifo_count=0, ovf=0, res_ready=1, FSM=IDLE, pointers=0.
- Derived constant: NBYTES = DATA_W/8.
- FIFO push:
  - Occurs when ena & res_valid & !full.
  - res_ready = !full, registered-state only; there is no combinational path from out_ack.
  - Push while full drops the word, even if a pop happens in the same cycle, and sets ovf.
- ovf:
  - Sets on a dropped word and clears on clr_ovf.
  - Set has priority over clr_ovf when both occur in the same cycle.
- FIFO pop: only the FSM pops, as defined below. A push and pop in the same cycle leave fifo_count unchanged.
- Pointers wrap modulo DEPTH. full = (count==DEPTH). empty = (count==0).
- FSM state IDLE:
  - out_valid=0.
  - If !empty: pop into shift register, byte_idx=0, go to SEND.
  - out_valid rises on the cycle after the pop (1-cycle latency from pop).
  - Minimum push-to-out_valid latency is 2 cycles when the FIFO is empty (push cycle, pop cycle, then visible).
- FSM state SEND:
  - out_valid=1, out_byte = shreg[8*byte_idx +: 8], out_last = (byte_idx==NBYTES-1).
  - On out_ack with !out_last: byte_idx++ and the new byte is visible next cycle.
  - On out_ack with out_last and !empty: pop the next word, byte_idx=0, stay in SEND. This is back-to-back with no IDLE bubble.
  - On out_ack with out_last and empty: go to IDLE and drop out_valid next cycle.
- out_ack while out_valid=0 is ignored.
- out_byte holds its last value in IDLE; it is not cleared.
- ena=0: no push (a res_valid is silently lost, ovf not set), no pop, out_ack ignored, all registers hold. Outputs keep their values.
- Reset mid-transfer: the partial word and all FIFO contents are discarded. Outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package pe_pkg: PE_RES_W=16, PE_FIFO_DEPTH=4, and the FSM state enum (IDLE, SEND) if enums are used in the tree.
- One sub-module: pe_sync_fifo (parameterized DATA_W/DEPTH).
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Registered storage with first-word data available combinationally at rdata.
- pe_result_drain holds the serializer FSM, shift register, byte index and ovf logic.

Test Plan:
- Single word: push 0xA55A with host acking every cycle -> out_byte 0x5A (out_last=0), then 0xA5 (out_last=1), then out_valid=0. First out_valid occurs exactly 2 cycles after the push.
- Back-to-back: push 0x1234, 0x5678, 0x9ABC in consecutive cycles, ack each byte 3 cycles after out_valid -> bytes 34,12,78,56,BC,9A in order. No IDLE cycle occurs between words; fifo_count peaks at 2.
- Overflow: with no acks, push 6 words -> fifo_count=4 and ovf=1. Then ack all bytes -> only the first 5 words appear (1 in the shift register plus 4 in the FIFO); the 6th is dropped.
- Overflow clear race: assert clr_ovf in the same cycle as a dropped push -> ovf stays 1. A later clr_ovf alone -> ovf=0.
- ena gating: drop ena while out_valid=1 and pulse out_ack and res_valid -> no byte advance, fifo_count unchanged, ovf unchanged. Restore ena -> resumes at the same byte.
- Async reset mid-word: assert rst_n=0 after the low byte is acked -> out_valid=0 and fifo_count=0 without a clock edge. After release, a new push 0x00FF -> 0xFF then 0x00.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants for the PE output path: default result width, FIFO depth
// and the serializer state encoding.
package pe_pkg;

    localparam int PE_RES_W      = 16;
    localparam int PE_FIFO_DEPTH = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/pe_sync_fifo.sv
// Single-clock FIFO with registered storage; the oldest word is presented
// combinationally on rdata. Callers guarantee no push when full, no pop when empty.
module pe_sync_fifo
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_RES_W,
    parameter int DEPTH  = PE_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    // NOTE: storage is deliberately not reset; count and the pointers decide
    // which entries are meaningful, so the array can map to plain flops or RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which is what makes a simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pe_result_drain.sv
// Drains PE result words through a small FIFO and serializes each word onto an
// 8-bit host bus, low byte first, holding every byte until the host acks it.
module pe_result_drain
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_RES_W,
    parameter int DEPTH  = PE_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [DATA_W-1:0]        res_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [0:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] fifo_rdata;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fire;
    logic              at_last;

    pe_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wdata  (res_data),
        .rdata  (fifo_rdata),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );

    // NOTE: every signal gets a default at the top so no path through this
    // block can leave one unassigned and infer a latch.
    always_comb begin
        push    = 1'b0;
        drop    = 1'b0;
        fire    = 1'b0;
        pop     = 1'b0;
        at_last = (byte_idx == LAST_IDX);
        if (ena) begin
            push = res_valid & ~full;
            drop = res_valid & full;
            fire = out_ack & (state == ST_SEND);
            // Reload straight from IDLE, or back-to-back when the last byte is acked.
            pop  = ~empty & ((state == ST_IDLE) | (fire & at_last));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            byte_idx <= '0;
        end else if (pop) begin
            state    <= ST_SEND;
            shreg    <= fifo_rdata;
            byte_idx <= '0;
        end else if (fire) begin
            if (at_last) state    <= ST_IDLE;
            else         byte_idx <= byte_idx + 1'b1;
        end
    end

    // A dropped word wins over a same-cycle clear so the loss is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ena && clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign res_ready = ~full;
    assign out_valid = (state == ST_SEND);
    assign out_last  = out_valid & at_last;
    assign out_byte  = shreg[{byte_idx, 3'b000} +: 8];

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed and randomized checks of pe_result_drain against a queue-based
// reference model of the FIFO-plus-serializer behaviour.
module tb_pe_result_drain;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int NB     = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_last;
    logic              out_ack;
    logic [2:0]        fifo_count;
    logic              ovf;
    logic              clr_ovf;

    pe_result_drain #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ack    (out_ack),
        .fifo_count (fifo_count),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pending words, word being sent, byte position, flag.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_cur;
    int                m_idx;
    bit                m_valid;
    bit                m_ovf;
    logic [7:0]        obs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur   = '0;
        m_idx   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic rv, input logic [DATA_W-1:0] d,
                              input logic a, input logic c);
        int sz;
        bit fire, last, take;
        if (!e) return;
        sz   = m_q.size();
        fire = m_valid && a;
        last = (m_idx == NB - 1);
        take = (sz > 0) && (!m_valid || (fire && last));
        if (take) begin
            m_cur   = m_q.pop_front();
            m_idx   = 0;
            m_valid = 1'b1;
        end else if (fire) begin
            if (last) m_valid = 1'b0;
            else      m_idx++;
        end
        if (rv && sz < DEPTH) m_q.push_back(d);
        if (rv && sz == DEPTH) m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        logic [7:0] eb;
        eb = 8'((m_cur >> (8 * m_idx)) & 'hFF);
        check("out_valid",  32'(out_valid),  32'(m_valid));
        check("out_byte",   32'(out_byte),   32'(eb));
        check("out_last",   32'(out_last),   32'(m_valid && m_idx == NB - 1));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("ovf",        32'(ovf),        32'(m_ovf));
        check("res_ready",  32'(res_ready),  32'(m_q.size() < DEPTH));
    endtask

    // One clock: drive inputs, log any completed handshake, advance model, compare.
    task automatic tick(input logic e, input logic rv, input logic [DATA_W-1:0] d,
                        input logic a, input logic c);
        ena = e; res_valid = rv; res_data = d; out_ack = a; clr_ovf = c;
        if (e && a && out_valid) obs.push_back(out_byte);
        model_step(e, rv, d, a, c);
        @(posedge clk);
        #1;
        compare_all();
        ena = 1'b1; res_valid = 1'b0; out_ack = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((out_valid || fifo_count != 0) && guard < 200) begin
            tick(1'b1, 1'b0, '0, out_valid, 1'b0);
            guard++;
        end
        check("drain_timeout", 32'(guard < 200), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(obs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            check(tag, 32'(obs[i]), 32'(exp[i]));
        obs.delete();
    endtask

    initial begin
        logic [7:0] exp_s[$];
        int         wait_cnt;
        int         gaps;
        int         peak;
        int         guard;
        bit         started;
        logic [7:0] held;
        logic [2:0] held_cnt;

        rst_n = 1'b0; ena = 1'b1; res_data = '0; res_valid = 1'b0;
        out_ack = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk) rst_n = 1'b1;

        // Single word, acked every cycle; out_valid appears two edges after push.
        tick(1'b1, 1'b1, 16'hA55A, 1'b0, 1'b0);
        check("lat_push_edge", 32'(out_valid), 32'd0);
        tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("lat_pop_edge", 32'(out_valid), 32'd1);
        check("single_lo", 32'(out_byte), 32'h5A);
        check("single_lo_last", 32'(out_last), 32'd0);
        tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("single_hi", 32'(out_byte), 32'hA5);
        check("single_hi_last", 32'(out_last), 32'd1);
        tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("single_done", 32'(out_valid), 32'd0);
        exp_s = '{8'h5A, 8'hA5};
        check_stream("single_stream", exp_s);

        // Back-to-back words, each byte acked after 3 cycles of visibility.
        tick(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
        peak = fifo_count;
        tick(1'b1, 1'b1, 16'h9ABC, 1'b0, 1'b0);
        if (fifo_count > peak) peak = fifo_count;
        wait_cnt = 0; gaps = 0; guard = 0; started = 1'b0;
        while (obs.size() < 6 && guard < 100) begin
            if (out_valid) begin
                started = 1'b1;
                wait_cnt++;
            end else if (started) begin
                gaps++;
            end
            tick(1'b1, 1'b0, '0, (wait_cnt == 3), 1'b0);
            if (wait_cnt == 3) wait_cnt = 0;
            if (fifo_count > peak) peak = fifo_count;
            guard++;
        end
        check("b2b_timeout", 32'(guard < 100), 32'd1);
        check("b2b_gaps", 32'(gaps), 32'd0);
        check("b2b_peak", 32'(peak), 32'd2);
        exp_s = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        check_stream("b2b_stream", exp_s);
        drain();

        // Overflow: six pushes with no acks keeps five words, drops the sixth.
        for (int i = 0; i < 6; i++)
            tick(1'b1, 1'b1, DATA_W'(16'h1100 + 16'h0101 * i), 1'b0, 1'b0);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_not_ready", 32'(res_ready), 32'd0);
        drain();
        exp_s.delete();
        for (int i = 0; i < 5; i++) begin
            exp_s.push_back(8'(8'h00 + i));
            exp_s.push_back(8'(8'h11 + i));
        end
        check_stream("ovf_stream", exp_s);

        // Clear racing a dropped push: set wins; a lone clear then works.
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("clr_alone1", 32'(ovf), 32'd0);
        for (int i = 0; i < 5; i++)
            tick(1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        check("race_pre", 32'(ovf), 32'd0);
        tick(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1);
        check("race_set_wins", 32'(ovf), 32'd1);
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("clr_alone2", 32'(ovf), 32'd0);
        drain();
        obs.delete();

        // ena gating freezes the byte position, FIFO and flag.
        tick(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
        held     = out_byte;
        held_cnt = fifo_count;
        tick(1'b0, 1'b1, 16'h1111, 1'b1, 1'b1);
        check("ena_byte", 32'(out_byte), 32'hEF);
        check("ena_byte_held", 32'(out_byte), 32'(held));
        check("ena_count", 32'(fifo_count), 32'(held_cnt));
        check("ena_ovf", 32'(ovf), 32'd0);
        tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("ena_resume", 32'(out_byte), 32'hBE);
        drain();
        exp_s = '{8'hEF, 8'hBE};
        check_stream("ena_stream", exp_s);

        // Asynchronous reset after the low byte is acked.
        tick(1'b1, 1'b1, 16'h1357, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 16'h2468, 1'b0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_count", 32'(fifo_count), 32'd0);
        compare_all();
        @(negedge clk) rst_n = 1'b1;
        obs.delete();
        tick(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0);
        drain();
        exp_s = '{8'hFF, 8'h00};
        check_stream("post_rst_stream", exp_s);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1), DATA_W'($urandom),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
        drain();
        obs.delete();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
